// File: rtl/approx_prod_acc.sv
// approx_prod_acc: accumulates a frame of up to LEN unsigned products from the
// approximate-multiplier array into one dot-product sum with valid/ready on both sides.
// Optional feature macro: APPROX_BIAS_COMP_EN adds BIAS to every accepted product.
module approx_prod_acc #(
   parameter  int unsigned PROD_W = 16,
   parameter  int unsigned LEN    = 8,
   parameter  int unsigned ACC_W  = 19,
   parameter  int unsigned BIAS   = 0,
   localparam int unsigned CNT_W  = $clog2(LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_ovf
);

   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             accept_c;
   logic             handshake_c;
   logic             final_c;
   logic [SUM_W-1:0] sum_c;
   logic [CNT_W-1:0] cnt_inc_c;
   logic             ovf_next_c;

   // The compensation constant must fit the widened adder or the carry flag lies.
   if ($clog2(BIAS + 1) > SUM_W) begin : g_bias_chk
      $error("approx_prod_acc: BIAS does not fit in ACC_W+1 bits");
   end

   // Next-sum datapath, one bit wider than the accumulator so the carry is visible.
   always_comb begin
      accept_c    = in_valid & in_ready;
      handshake_c = out_valid & out_ready;
`ifdef APPROX_BIAS_COMP_EN
      sum_c       = {1'b0, acc} + SUM_W'(in_prod) + SUM_W'(BIAS);
`else
      sum_c       = {1'b0, acc} + SUM_W'(in_prod);
`endif
      cnt_inc_c   = cnt + CNT_W'(1);
      ovf_next_c  = ovf | sum_c[ACC_W];
      final_c     = (cnt_inc_c == CNT_W'(LEN)) | in_last;
   end

   // Frame FSM with registered handshake outputs and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cnt   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (accept_c) begin
                  acc <= sum_c[ACC_W-1:0];
                  cnt <= cnt_inc_c;
                  ovf <= ovf_next_c;
                  if (final_c) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_sum   <= sum_c[ACC_W-1:0];
                     out_cnt   <= cnt_inc_c;
                     out_ovf   <= ovf_next_c;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            HOLD: begin
               if (handshake_c) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_approx_prod_acc.sv
// tb_approx_prod_acc: directed table-driven bench for approx_prod_acc.
// Three instances share one stimulus: defaults, BIAS=4, and ACC_W=16.
module tb_approx_prod_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_prod;
   logic        in_last;
   logic        out_ready;

   logic        in_ready0, in_ready1, in_ready2;
   logic        out_valid0, out_valid1, out_valid2;
   logic [18:0] out_sum0, out_sum1;
   logic [15:0] out_sum2;
   logic [3:0]  out_cnt0, out_cnt1, out_cnt2;
   logic        out_ovf0, out_ovf1, out_ovf2;

   int          checks = 0;
   int          errors = 0;
   int          sel = 0;

   logic        o_ready, o_valid, o_ovf;
   logic [31:0] o_sum;
   logic [3:0]  o_cnt;

   always #5 clk = ~clk;

   approx_prod_acc dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_prod(in_prod),
      .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
      .out_cnt(out_cnt0), .out_ovf(out_ovf0));

   approx_prod_acc #(.BIAS(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_prod(in_prod),
      .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
      .out_cnt(out_cnt1), .out_ovf(out_ovf1));

   approx_prod_acc #(.ACC_W(16)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_prod(in_prod),
      .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
      .out_cnt(out_cnt2), .out_ovf(out_ovf2));

   // Observe the instance under test.
   always_comb begin
      case (sel)
         1: begin
            o_ready = in_ready1; o_valid = out_valid1; o_sum = 32'(out_sum1);
            o_cnt = out_cnt1; o_ovf = out_ovf1;
         end
         2: begin
            o_ready = in_ready2; o_valid = out_valid2; o_sum = 32'(out_sum2);
            o_cnt = out_cnt2; o_ovf = out_ovf2;
         end
         default: begin
            o_ready = in_ready0; o_valid = out_valid0; o_sum = 32'(out_sum0);
            o_cnt = out_cnt0; o_ovf = out_ovf0;
         end
      endcase
   end

   typedef struct packed {
      logic [1:0]       sel;
      logic [3:0]       n;
      logic             last;
      logic [7:0][15:0] prods;
      logic [31:0]      sum;
      logic [3:0]       cnt;
      logic             ovf;
   } vec_t;

   localparam int NVEC = 8;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Present one product and hold it until accepted.
   task automatic push(input logic [15:0] p, input logic last);
      int guard = 0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = last;
      while (!o_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (guard >= 50) begin
         errors++;
         $display("FAIL push_timeout: in_ready stuck at %0b, required 1", o_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Complete the output handshake.
   task automatic drain();
      int guard = 0;
      out_ready = 1'b1;
      while (!o_valid && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (guard >= 50) begin
         errors++;
         $display("FAIL drain_timeout: out_valid stuck at %0b, required 1", o_valid);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{sel: 2'd0, n: 4'd8, last: 1'b0, prods: {8{16'hFE01}}, sum: 32'd520200, cnt: 4'd8, ovf: 1'b0};
      vecs[1] = '{sel: 2'd0, n: 4'd3, last: 1'b1, prods: '0, sum: 32'd60, cnt: 4'd3, ovf: 1'b0};
      vecs[1].prods[0] = 16'd10;
      vecs[1].prods[1] = 16'd20;
      vecs[1].prods[2] = 16'd30;
      vecs[2] = '{sel: 2'd0, n: 4'd1, last: 1'b1, prods: {8{16'd5}}, sum: 32'd5, cnt: 4'd1, ovf: 1'b0};
      vecs[3] = '{sel: 2'd0, n: 4'd8, last: 1'b0, prods: {8{16'hFFFF}}, sum: 32'd524280, cnt: 4'd8, ovf: 1'b0};
      vecs[4] = '{sel: 2'd0, n: 4'd8, last: 1'b1, prods: {8{16'd1}}, sum: 32'd8, cnt: 4'd8, ovf: 1'b0};
`ifdef APPROX_BIAS_COMP_EN
      vecs[5] = '{sel: 2'd1, n: 4'd8, last: 1'b0, prods: {8{16'd100}}, sum: 32'd832, cnt: 4'd8, ovf: 1'b0};
`else
      vecs[5] = '{sel: 2'd1, n: 4'd8, last: 1'b0, prods: {8{16'd100}}, sum: 32'd800, cnt: 4'd8, ovf: 1'b0};
`endif
      vecs[6] = '{sel: 2'd2, n: 4'd2, last: 1'b1, prods: {8{16'hFFFF}}, sum: 32'h0000FFFE, cnt: 4'd2, ovf: 1'b1};
      vecs[7] = '{sel: 2'd2, n: 4'd1, last: 1'b1, prods: {8{16'd5}}, sum: 32'd5, cnt: 4'd1, ovf: 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      chk("reset_out_valid", 32'(o_valid), 32'd0);
      chk("reset_in_ready", 32'(o_ready), 32'd1);
      chk("reset_out_sum", o_sum, 32'd0);
      chk("reset_out_cnt", 32'(o_cnt), 32'd0);
      chk("reset_out_ovf", 32'(o_ovf), 32'd0);

      // Table-driven frames.
      for (int i = 0; i < NVEC; i++) begin
         sel = int'(vecs[i].sel);
         for (int k = 0; k < int'(vecs[i].n); k++) begin
            if (k == int'(vecs[i].n) - 1) chk($sformatf("v%0d_early_valid", i), 32'(o_valid), 32'd0);
            push(vecs[i].prods[k], (k == int'(vecs[i].n) - 1) && vecs[i].last);
         end
         chk($sformatf("v%0d_out_valid", i), 32'(o_valid), 32'd1);
         chk($sformatf("v%0d_hold_in_ready", i), 32'(o_ready), 32'd0);
         chk($sformatf("v%0d_out_sum", i), o_sum, vecs[i].sum);
         chk($sformatf("v%0d_out_cnt", i), 32'(o_cnt), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_out_ovf", i), 32'(o_ovf), 32'(vecs[i].ovf));
         drain();
         chk($sformatf("v%0d_post_valid", i), 32'(o_valid), 32'd0);
         chk($sformatf("v%0d_post_in_ready", i), 32'(o_ready), 32'd1);
         chk($sformatf("v%0d_retained_sum", i), o_sum, vecs[i].sum);
      end

      // Backpressure: result held while a new product waits upstream.
      sel = 0;
      push(16'd1, 1'b0);
      push(16'd2, 1'b1);
      in_valid = 1'b1; in_prod = 16'd7; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(o_valid), 32'd1);
         chk("bp_out_sum", o_sum, 32'd3);
         chk("bp_in_ready", 32'(o_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_after_hs_valid", 32'(o_valid), 32'd0);
      chk("bp_after_hs_in_ready", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      chk("bp_next_valid", 32'(o_valid), 32'd1);
      chk("bp_next_sum", o_sum, 32'd7);
      chk("bp_next_cnt", 32'(o_cnt), 32'd1);
      drain();

      // Reset mid-frame discards partial sum.
      for (int k = 0; k < 4; k++) push(16'd100, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_valid", 32'(o_valid), 32'd0);
      chk("rst_mid_in_ready", 32'(o_ready), 32'd1);
      chk("rst_mid_sum", o_sum, 32'd0);
      push(16'd1, 1'b0);
      push(16'd2, 1'b1);
      chk("rst_after_valid", 32'(o_valid), 32'd1);
      chk("rst_after_sum", o_sum, 32'd3);
      chk("rst_after_cnt", 32'(o_cnt), 32'd2);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
